des_key_schedule: RTL and testbench

- Upstream neighbour of the DES round function: produces the sixteen 48-bit round subkeys, one per round, from a 64-bit key.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- Subkeys are delivered over a valid/ready handshake, so the round controller pulls one subkey per round.

---
 rtl/des_pkg.sv | 62 ++++++
 rtl/des_pc2.sv | 19 +
 rtl/des_key_schedule.sv | 131 +++++++++++++
 tb/tb_des_key_schedule.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers, shared with the round datapath.
// Optional parity checking in the top is enabled by DES_KEY_PARITY_CHECK_EN.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2,
        1, 2, 2, 2, 2, 2, 2, 1
    };

    typedef enum logic {
        IDLE,
        GEN
    } ks_state_t;

    function automatic logic shift2(input int r);
        return SHIFT[r] == 2;
    endfunction

    // Rotate one 28-bit half by 1 or 2 places.
    function automatic logic [HALF_W-1:0] rot(
        input logic [HALF_W-1:0] x,
        input logic              left,
        input logic              two
    );
        logic [HALF_W-1:0] r;
        unique case ({left, two})
            2'b11:   r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            2'b10:   r = {x[HALF_W-2:0], x[HALF_W-1]};
            2'b01:   r = {x[1:0], x[HALF_W-1:2]};
            default: r = {x[0], x[HALF_W-1:1]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit C||D to 48-bit round subkey.
// Purely combinational; DES bit 1 is the MSB on both sides.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*HALF_W-1:0] cd,
    output logic [SUBKEY_W-1:0] subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        assign subkey[SUBKEY_W-1-i] = cd[2*HALF_W-PC2[i]];
    end

    // PC-2 discards C||D bits 9,18,22,25,35,38,43,54.
    logic unused_cd;
    assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31],
                         cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator with encrypt/decrypt order and valid/ready output.
// Define DES_KEY_PARITY_CHECK_EN to reject keys failing per-byte odd parity.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = ROUNDS,
    localparam int RW = $clog2(NUM_ROUNDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key,
    input  logic                key_en,
    input  logic                decrypt,
    output logic                key_rdy,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_vld,
    input  logic                subkey_rdy,
    output logic [RW-1:0]       round_idx,
    output logic                done,
    output logic                key_err
);

    ks_state_t         state, state_nxt;
    logic [HALF_W-1:0] c_q, d_q, c_nxt, d_nxt;
    logic [RW-1:0]     idx_q, idx_nxt;
    logic              dec_q, dec_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic [2*HALF_W-1:0] cd0;
    logic              par_ok;
    logic              two;

    for (genvar i = 0; i < 2*HALF_W; i++) begin : g_pc1
        assign cd0[2*HALF_W-1-i] = key[KEY_W-PC1[i]];
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic [7:0] byte_odd;
    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^key[8*b +: 8];
    end
    assign par_ok = &byte_odd;
`else
    logic unused_par;
    assign unused_par = ^{key[56], key[48], key[40], key[32],
                          key[24], key[16], key[8], key[0]};
    assign par_ok = 1'b1;
`endif

    // Encrypt steps forward with s(i+2); decrypt walks back with s(16-i).
    always_comb begin
        two = 1'b0;
        if (dec_q)
            two = shift2(NUM_ROUNDS - 1 - int'(idx_q));
        else if (idx_q != RW'(NUM_ROUNDS - 1))
            two = shift2(int'(idx_q) + 1);
    end

    always_comb begin
        state_nxt = state;
        c_nxt     = c_q;
        d_nxt     = d_q;
        idx_nxt   = idx_q;
        dec_nxt   = dec_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_en && par_ok) begin
                    state_nxt = GEN;
                    idx_nxt   = '0;
                    dec_nxt   = decrypt;
                    c_nxt     = cd0[2*HALF_W-1:HALF_W];
                    d_nxt     = cd0[HALF_W-1:0];
                    if (!decrypt) begin
                        c_nxt = rot(cd0[2*HALF_W-1:HALF_W], 1'b1, shift2(0));
                        d_nxt = rot(cd0[HALF_W-1:0], 1'b1, shift2(0));
                    end
                end else if (key_en) begin
                    err_nxt = 1'b1;
                end
            end
            GEN: begin
                if (subkey_rdy) begin
                    if (idx_q == RW'(NUM_ROUNDS - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        c_nxt   = rot(c_q, !dec_q, two);
                        d_nxt   = rot(d_q, !dec_q, two);
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            c_q    <= '0;
            d_q    <= '0;
            idx_q  <= '0;
            dec_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            c_q    <= c_nxt;
            d_q    <= d_nxt;
            idx_q  <= idx_nxt;
            dec_q  <= dec_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

    assign key_rdy    = (state == IDLE);
    assign subkey_vld = (state == GEN);
    assign round_idx  = idx_q;
    assign done       = done_q;
    assign key_err    = err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a cumulative-shift DES model.
// Parity-reject checks run when DES_KEY_PARITY_CHECK_EN is defined.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key;
    logic        key_en;
    logic        decrypt;
    logic        key_rdy;
    logic [47:0] subkey;
    logic        subkey_vld;
    logic        subkey_rdy;
    logic [3:0]  round_idx;
    logic        done;
    logic        key_err;

    int total = 0;
    int bad   = 0;

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] exp_k [16];
    logic [47:0] seen  [16];

    des_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_en     (key_en),
        .decrypt    (decrypt),
        .key_rdy    (key_rdy),
        .subkey     (subkey),
        .subkey_vld (subkey_vld),
        .subkey_rdy (subkey_rdy),
        .round_idx  (round_idx),
        .done       (done),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Round r (1..16) subkey: halves rotated left by the sum of s1..sr.
    function automatic logic [47:0] model_key(input logic [63:0] k,
                                              input int r);
        logic [55:0] cd;
        logic [63:0] c, d;
        logic [47:0] o;
        int tot = 0;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        for (int i = 0; i < r; i++) tot += SH_T[i];
        c = {36'd0, cd[55:28]};
        d = {36'd0, cd[27:0]};
        c = ((c << tot) | (c >> (28 - tot))) & 64'hFFF_FFFF;
        d = ((d << tot) | (d >> (28 - tot))) & 64'hFFF_FFFF;
        cd = {c[27:0], d[27:0]};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    task automatic build(input logic [63:0] k, input logic dec);
        for (int n = 0; n < 16; n++)
            exp_k[n] = dec ? model_key(k, 16 - n) : model_key(k, n + 1);
    endtask

    function automatic logic [63:0] make_odd(input logic [63:0] k);
        logic [63:0] r = k;
        for (int b = 0; b < 8; b++) r[8*b] = ~(^r[8*b+1 +: 7]);
        return r;
    endfunction

    // mode 0: always ready, 1: toggle starting stalled, 2: random ready.
    task automatic run_key(input logic [63:0] k, input logic dec,
                           input int mode);
        int n = 0;
        int c = 0;
        int rdy;
        build(k, dec);
        chk("idle_rdy", key_rdy, 1);
        key = k;
        decrypt = dec;
        key_en = 1'b1;
        subkey_rdy = 1'b0;
        cyc();
        key_en = 1'b0;
        key = ~k;
        decrypt = ~dec;
        while (n < 16 && c < 100) begin
            chk("vld", subkey_vld, 1);
            chk("subkey", subkey, exp_k[n]);
            chk("round_idx", round_idx, n);
            chk("done_low", done, 0);
            chk("key_err_low", key_err, 0);
            rdy = (mode == 0) ? 1 : (mode == 1) ? (c % 2)
                : int'($urandom_range(0, 1));
            subkey_rdy = (rdy != 0);
            if (rdy != 0) seen[n] = subkey;
            cyc();
            if (rdy != 0) n++;
            c++;
        end
        chk("handshakes", n, 16);
        if (mode == 0) chk("latency", c, 16);
        chk("done_pulse", done, 1);
        chk("vld_off", subkey_vld, 0);
        chk("rdy_back", key_rdy, 1);
        subkey_rdy = 1'b0;
        cyc();
        chk("done_one_cycle", done, 0);
    endtask

    localparam logic [63:0] KAT = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] BADK = 64'h1234_5779_9BBC_DFF1;

    initial begin
        logic [63:0] ka, kb;
        rst = 1'b1;
        key = '0;
        key_en = 1'b0;
        decrypt = 1'b0;
        subkey_rdy = 1'b0;
        cyc();
        cyc();
        chk("rst_key_rdy", key_rdy, 1);
        chk("rst_vld", subkey_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_subkey", subkey, 0);
        rst = 1'b0;
        cyc();

        run_key(KAT, 1'b0, 0);
        chk("kat_enc_k1", seen[0], 48'h1B02EFFC7072);
        chk("kat_enc_k2", seen[1], 48'h79AED9DBC9E5);
        chk("kat_enc_k16", seen[15], 48'hCB3D8B0E17F5);

        run_key(KAT, 1'b1, 0);
        chk("kat_dec_first", seen[0], 48'hCB3D8B0E17F5);
        chk("kat_dec_last", seen[15], 48'h1B02EFFC7072);

        run_key(KAT, 1'b0, 1);

        // Busy key_en ignored, then reset abandons the sequence.
        ka = make_odd({$urandom, $urandom});
        kb = make_odd({$urandom, $urandom});
        build(ka, 1'b0);
        key = ka;
        decrypt = 1'b0;
        key_en = 1'b1;
        subkey_rdy = 1'b1;
        cyc();
        key_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("busy_subkey", subkey, exp_k[i]);
            chk("busy_idx", round_idx, i);
            key_en = (i == 5);
            key = kb;
            decrypt = 1'b1;
            cyc();
        end
        key_en = 1'b0;
        chk("pre_rst_subkey", subkey, exp_k[9]);
        chk("pre_rst_idx", round_idx, 9);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        subkey_rdy = 1'b0;
        chk("mid_rst_vld", subkey_vld, 0);
        chk("mid_rst_key_rdy", key_rdy, 1);
        chk("mid_rst_idx", round_idx, 0);
        chk("mid_rst_done", done, 0);
        cyc();
        chk("mid_rst_no_done", done, 0);
        run_key(ka, 1'b0, 0);

        // Back-to-back with key_en held high throughout.
        ka = make_odd({$urandom, $urandom});
        kb = make_odd({$urandom, $urandom});
        build(ka, 1'b0);
        key = ka;
        decrypt = 1'b0;
        key_en = 1'b1;
        subkey_rdy = 1'b1;
        cyc();
        key = kb;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_a_vld", subkey_vld, 1);
            chk("b2b_a_subkey", subkey, exp_k[i]);
            cyc();
        end
        chk("b2b_done", done, 1);
        chk("b2b_gap_vld", subkey_vld, 0);
        chk("b2b_key_rdy", key_rdy, 1);
        build(kb, 1'b0);
        cyc();
        key_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_b_vld", subkey_vld, 1);
            chk("b2b_b_subkey", subkey, exp_k[i]);
            chk("b2b_b_idx", round_idx, i);
            cyc();
        end
        chk("b2b_b_done", done, 1);
        subkey_rdy = 1'b0;
        cyc();

`ifdef DES_KEY_PARITY_CHECK_EN
        key = BADK;
        decrypt = 1'b0;
        key_en = 1'b1;
        cyc();
        key_en = 1'b0;
        chk("par_err_pulse", key_err, 1);
        chk("par_err_vld", subkey_vld, 0);
        chk("par_err_idle", key_rdy, 1);
        cyc();
        chk("par_err_clear", key_err, 0);
        chk("par_err_still_idle", subkey_vld, 0);
        run_key(KAT, 1'b0, 0);
`else
        run_key(BADK, 1'b0, 0);
`endif

        for (int r = 0; r < 6; r++)
            run_key(make_odd({$urandom, $urandom}),
                    1'($urandom_range(0, 1)), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
